mem_port_arbiter: RTL and testbench

Shares the single main-memory port between two requesters: the instruction-fetch side (read only) and the data-cache controller (line fill and write-back, read/write).
- Sits between the core and the memory model, which has a fixed multi-cycle access latency.
- Uses a req/done handshake per requester, round-robin arbitration on ties, and a latency counter.
- Owns mem_addr, mem_data_in and mem_write_en exclusively.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_arb_latency_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owner, and byte-lane packing helpers.
// Byte lane k of a memory word always carries word bits 8k+7:8k, independent of array direction.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    typedef logic [0:3][7:0] bytes_t;

    function automatic bytes_t to_bytes(input logic [31:0] word);
        bytes_t b;
        for (int k = 0; k < 4; k++) begin
            b[k] = word[8*k +: 8];
        end
        return b;
    endfunction

    function automatic logic [31:0] from_bytes(input bytes_t b);
        logic [31:0] word;
        for (int k = 0; k < 4; k++) begin
            word[8*k +: 8] = b[k];
        end
        return word;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (I/D) and memory-side signals of the arbiter; slave = arbiter view, master = core + memory view.
// No flow control beyond req held until done.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic                 i_req;
    logic [XLEN-1:0]      i_addr;
    logic                 i_done;
    logic [XLEN-1:0]      i_rdata;
    logic                 d_req;
    logic                 d_we;
    logic [XLEN-1:0]      d_addr;
    logic [XLEN-1:0]      d_wdata;
    logic                 d_done;
    logic [XLEN-1:0]      d_rdata;
    logic                 busy;
    logic [XLEN-1:0]      mem_addr;
    mem_arb_pkg::bytes_t  mem_data_in;
    mem_arb_pkg::bytes_t  mem_data_out;
    logic                 mem_write_en;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_done, i_rdata, d_done, d_rdata, busy, mem_addr, mem_data_in, mem_write_en
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_done, i_rdata, d_done, d_rdata, busy, mem_addr, mem_data_in, mem_write_en
    );
endinterface

// File: rtl/mem_arb_latency_ctr.sv
// Access-window down-counter: load starts a MEM_LATENCY-cycle window; expired_o marks its final cycle.
// expired_o is combinational from the count register; counting stalls at zero.
module mem_arb_latency_ctr #(
    parameter int MEM_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(MEM_LATENCY - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port for I-fetch and D-cache; done pulses MEM_LATENCY+1 cycles after grant.
// Requesters hold req until done; a losing or late request simply waits for the next IDLE cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    mem_port_arbiter_if.slave  bus
);
    state_t          state_q;
    owner_t          owner_q;
    owner_t          last_owner_q;
    logic [XLEN-1:0] mem_addr_q;
    bytes_t          mem_data_in_q;
    logic            mem_we_q;
    logic [XLEN-1:0] i_rdata_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            i_done_q;
    logic            d_done_q;
    logic            busy_q;

    logic any_req;
    logic grant_d;
    logic expired;

    assign any_req = bus.i_req | bus.d_req;
    // On a tie the side that did not win last time is served.
    assign grant_d = bus.d_req & (~bus.i_req | (last_owner_q == OWN_I));

    mem_arb_latency_ctr #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_latency_ctr (
        .clk       (clk),
        .rst_b     (rst_b),
        .load_i    ((state_q == IDLE) && any_req),
        .en_i      (state_q == BUSY),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            last_owner_q  <= OWN_I;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        if (grant_d) begin
                            owner_q       <= OWN_D;
                            last_owner_q  <= OWN_D;
                            mem_addr_q    <= bus.d_addr;
                            mem_data_in_q <= to_bytes(bus.d_wdata);
                            mem_we_q      <= bus.d_we;
                        end else begin
                            owner_q      <= OWN_I;
                            last_owner_q <= OWN_I;
                            mem_addr_q   <= bus.i_addr;
                            mem_we_q     <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    if (expired) begin
                        state_q  <= RESP;
                        mem_we_q <= 1'b0;
                        if (owner_q == OWN_D) begin
                            d_rdata_q <= from_bytes(bus.mem_data_out);
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= from_bytes(bus.mem_data_out);
                            i_done_q  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    owner_q <= OWN_NONE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_done       = i_done_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_done       = d_done_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.busy         = busy_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_data_in  = mem_data_in_q;
    assign bus.mem_write_en = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers push expected completions, a negedge monitor pops and checks them.
module tb_mem_port_arbiter;
    localparam int LAT = 4;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_b = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    exp_t i_q[$];
    exp_t d_q[$];
    logic [31:0] env_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    bit fair_on = 1'b0;
    int fair_last = 0;

    mem_port_arbiter_if #(.XLEN(32)) a_if ();
    mem_port_arbiter_if #(.XLEN(32)) b_if ();

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(LAT)) u_a (.clk(clk), .rst_b(rst_b), .bus(a_if));
    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1))   u_b (.clk(clk), .rst_b(rst_b), .bus(b_if));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic mem_arb_pkg::bytes_t tb_split(input logic [31:0] w);
        mem_arb_pkg::bytes_t b;
        b[0] = w[7:0];
        b[1] = w[15:8];
        b[2] = w[23:16];
        b[3] = w[31:24];
        return b;
    endfunction

    function automatic logic [31:0] tb_join(input mem_arb_pkg::bytes_t b);
        return {b[3], b[2], b[1], b[0]};
    endfunction

    // Memory models: writes land on the edge, read data follows the address by half a cycle.
    always @(posedge clk) begin
        if (a_if.mem_write_en) env_mem[a_if.mem_addr] = tb_join(a_if.mem_data_in);
    end
    always @(negedge clk) begin
        a_if.mem_data_out = tb_split(env_mem.exists(a_if.mem_addr) ? env_mem[a_if.mem_addr] : dflt(a_if.mem_addr));
        b_if.mem_data_out = tb_split(32'hCAFE_0000 ^ b_if.mem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_if.i_done) begin
            if (i_q.size() == 0) chk("i_spurious_done", a_if.i_done, 1'b0);
            else begin
                e = i_q.pop_front();
                if (e.chk_data) chk("i_rdata", a_if.i_rdata, e.data);
                if (e.cyc >= 0) chk("i_done_cycle", cyc, e.cyc);
            end
        end
        if (a_if.d_done) begin
            if (d_q.size() == 0) chk("d_spurious_done", a_if.d_done, 1'b0);
            else begin
                e = d_q.pop_front();
                if (e.chk_data) chk("d_rdata", a_if.d_rdata, e.data);
                if (e.cyc >= 0) chk("d_done_cycle", cyc, e.cyc);
            end
        end
        if (fair_on && (a_if.i_done || a_if.d_done)) begin
            if (fair_last != 0) chk("fair_alternate", (a_if.d_done ? 2 : 1) != fair_last, 1'b1);
            fair_last = a_if.d_done ? 2 : 1;
        end
    end

    task automatic i_access(input logic [31:0] addr, input int lat, output int we_cnt, output int busy_cnt);
        exp_t e;
        int   n;
        e.data = ref_rd(addr);
        e.chk_data = 1'b1;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        i_q.push_back(e);
        a_if.i_addr = addr;
        a_if.i_req = 1'b1;
        we_cnt = 0;
        busy_cnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (a_if.mem_write_en) we_cnt++;
            if (a_if.busy) busy_cnt++;
        end while (!a_if.i_done && n < 100);
        if (!a_if.i_done) chk("i_done_timeout", a_if.i_done, 1'b1);
        a_if.i_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                            output int we_cnt, output int busy_cnt, output logic [7:0] byte0);
        exp_t e;
        int   n;
        e.data = we ? 32'h0 : ref_rd(addr);
        e.chk_data = !we;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        if (we) ref_mem[addr] = wdata;
        d_q.push_back(e);
        a_if.d_we = we;
        a_if.d_addr = addr;
        a_if.d_wdata = wdata;
        a_if.d_req = 1'b1;
        we_cnt = 0;
        busy_cnt = 0;
        byte0 = 8'h0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (a_if.mem_write_en) begin
                we_cnt++;
                byte0 = a_if.mem_data_in[0];
            end
            if (a_if.busy) busy_cnt++;
        end while (!a_if.d_done && n < 100);
        if (!a_if.d_done) chk("d_done_timeout", a_if.d_done, 1'b1);
        a_if.d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_c, bz_c, we_c2, bz_c2, s, n;
        logic [7:0] b0;
        a_if.i_req = 0; a_if.i_addr = 0; a_if.d_req = 0; a_if.d_we = 0; a_if.d_addr = 0; a_if.d_wdata = 0;
        b_if.i_req = 0; b_if.i_addr = 0; b_if.d_req = 0; b_if.d_we = 0; b_if.d_addr = 0; b_if.d_wdata = 0;
        env_mem[32'h40] = 32'h1234_5678;
        ref_mem[32'h40] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        chk("rst_busy", a_if.busy, 1'b0);
        chk("rst_mem_we", a_if.mem_write_en, 1'b0);
        chk("rst_mem_addr", a_if.mem_addr, 32'h0);
        chk("rst_mem_data_in", a_if.mem_data_in, 32'h0);
        chk("rst_i_done", a_if.i_done, 1'b0);
        chk("rst_d_done", a_if.d_done, 1'b0);
        chk("rst_i_rdata", a_if.i_rdata, 32'h0);
        chk("rst_d_rdata", a_if.d_rdata, 32'h0);
        rst_b = 1'b0;
        @(negedge clk);

        // First tie after reset goes to D; I follows in the next IDLE.
        fork
            d_access(1'b0, 32'h500, 32'h0, LAT + 1, we_c, bz_c, b0);
            i_access(32'h40, 2 * LAT + 3, we_c2, bz_c2);
        join

        i_access(32'h40, LAT + 1, we_c, bz_c);
        chk("i_read_we_cycles", we_c, 0);
        chk("i_read_busy_cycles", bz_c, LAT + 1);

        d_access(1'b1, 32'h100, 32'hDEAD_BEEF, LAT + 1, we_c, bz_c, b0);
        chk("d_write_we_cycles", we_c, LAT);
        chk("d_write_byte0", b0, 8'hEF);
        d_access(1'b0, 32'h100, 32'h0, LAT + 1, we_c, bz_c, b0);
        chk("d_read_we_cycles", we_c, 0);

        // Both held high: last owner is I here, so D, I, D, I.
        i_access(32'h1040, LAT + 1, we_c, bz_c);
        s = cyc;
        d_q.push_back('{ref_rd(32'h300), s + LAT + 1, 1'b1});
        d_q.push_back('{ref_rd(32'h300), s + 3 * LAT + 5, 1'b1});
        i_q.push_back('{ref_rd(32'h1044), s + 2 * LAT + 3, 1'b1});
        i_q.push_back('{ref_rd(32'h1044), s + 4 * LAT + 7, 1'b1});
        fair_last = 0;
        fair_on = 1'b1;
        a_if.d_we = 1'b0; a_if.d_addr = 32'h300; a_if.d_req = 1'b1;
        a_if.i_addr = 32'h1044; a_if.i_req = 1'b1;
        repeat (4 * LAT + 7) @(negedge clk);
        a_if.d_req = 1'b0;
        a_if.i_req = 1'b0;
        @(negedge clk);
        fair_on = 1'b0;

        // Reset during the second BUSY cycle of a write abandons it silently.
        a_if.d_we = 1'b1; a_if.d_addr = 32'h200; a_if.d_wdata = 32'h0BAD_F00D; a_if.d_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_we_before", a_if.mem_write_en, 1'b1);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_mid_we_after", a_if.mem_write_en, 1'b0);
        chk("rst_mid_busy_after", a_if.busy, 1'b0);
        rst_b = 1'b0;
        a_if.d_req = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            chk("rst_mid_no_done", a_if.d_done, 1'b0);
        end
        d_access(1'b1, 32'h200, 32'h5555_AAAA, LAT + 1, we_c, bz_c, b0);
        chk("post_rst_we_cycles", we_c, LAT);
        d_access(1'b0, 32'h200, 32'h0, LAT + 1, we_c, bz_c, b0);

        fork
            begin
                int w, b;
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    i_access(32'h1000 + (32'($urandom_range(0, 15)) << 2), -1, w, b);
                end
            end
            begin
                int w, b;
                logic [7:0] x;
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    d_access(1'($urandom_range(0, 1)), 32'h2000 + (32'($urandom_range(0, 7)) << 2), $urandom, -1, w, b, x);
                end
            end
        join

        // Single-cycle latency instance.
        @(negedge clk);
        s = cyc;
        b_if.i_addr = 32'h80;
        b_if.i_req = 1'b1;
        n = 0;
        bz_c = 0;
        do begin
            @(negedge clk);
            n++;
            if (b_if.busy) bz_c++;
        end while (!b_if.i_done && n < 20);
        chk("l1_done_cycle", cyc, s + 2);
        chk("l1_rdata", b_if.i_rdata, 32'hCAFE_0080);
        b_if.i_req = 1'b0;
        @(negedge clk);
        chk("l1_busy_cycles", bz_c, 2);
        chk("l1_idle_after", b_if.busy, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drain", i_q.size() + d_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
